// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment count display.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    // Shift-add-3 correction step for one BCD nibble.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        return (digit <= 4'd9) ? SEG_LUT[digit] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg7_count_display_bin2bcd.sv
// Sequential shift-add-3 binary to two-digit BCD converter.
// start loads bin; done is high during the cycle whose edge performs the last shift.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic             done,
    output logic [3:0]       units,
    output logic [2:0]       tens
);

    logic [CNT_W-1:0] bin_q;
    logic [3:0]       units_q;
    logic [2:0]       tens_q;
    logic [2:0]       shift_cnt_q;
    logic             active_q;
    logic [3:0]       units_adj;

    assign units_adj = add3(units_q);
    assign done      = active_q && (shift_cnt_q == 3'(CNT_W - 1));
    assign units     = units_q;
    assign tens      = tens_q;

    // Values never exceed 63, so tens is at most 3 before the final shift and
    // its add-3 correction can never fire; only the units nibble is adjusted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_q       <= '0;
            units_q     <= '0;
            tens_q      <= '0;
            shift_cnt_q <= '0;
            active_q    <= 1'b0;
        end else if (start) begin
            bin_q       <= bin;
            units_q     <= '0;
            tens_q      <= '0;
            shift_cnt_q <= '0;
            active_q    <= 1'b1;
        end else if (active_q) begin
            // NOTE: state registers use non-blocking assignment so every update
            // below reads the pre-edge values, exactly like the hardware.
            bin_q       <= bin_q << 1;
            units_q     <= {units_adj[2:0], bin_q[CNT_W-1]};
            tens_q      <= {tens_q[1:0], units_adj[3]};
            shift_cnt_q <= shift_cnt_q + 3'd1;
            if (done) active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seg7_count_display.sv
// Count display: samples count on time ticks, converts to BCD, multiplexes two digits.
// Optional feature macro: SEG_BLINK_EN (blink the display while max/min is latched).
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int          CNT_W       = 5,
`ifdef SEG_BLINK_EN
    parameter logic [3:0]  BLINK_DIV   = 4'd5,
`endif
    parameter logic [23:0] REFRESH_DIV = 24'd50_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             time_i,
    input  logic             max_i,
    input  logic             min_i,
    output logic [6:0]       seg_o,
    output logic             dp_o,
    output logic [1:0]       dig_o,
    output logic             busy_o
);

    state_t state_q, state_d;

    logic             start, commit, sh_load, ld_max, ld_min;
    logic [CNT_W-1:0] bin;
    logic             done;
    logic [3:0]       units;
    logic [2:0]       tens;

    logic             pend_q, pend_max_q, pend_min_q;
    logic [CNT_W-1:0] pend_cnt_q;
    logic             sh_max_q, sh_min_q;
    logic [3:0]       disp_units_q;
    logic [2:0]       disp_tens_q;
    logic             disp_max_q, disp_min_q, flag;

    logic [23:0]      ref_q;
    logic             wrap, phase_q;
    logic [6:0]       seg_d, seg_q;
    logic             dp_d, dp_q;
    logic [1:0]       dig_q;

    bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (start),
        .bin    (bin),
        .done   (done),
        .units  (units),
        .tens   (tens)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        sh_load = 1'b0;
        bin     = cnt_i;
        ld_max  = max_i;
        ld_min  = min_i;
        unique case (state_q)
            IDLE: if (time_i) begin
                start   = 1'b1;
                sh_load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: if (done) state_d = COMMIT;
            COMMIT: begin
                commit = 1'b1;
                if (pend_q) begin
                    start   = 1'b1;
                    sh_load = 1'b1;
                    bin     = pend_cnt_q;
                    ld_max  = pend_max_q;
                    ld_min  = pend_min_q;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A tick while busy (COMMIT included) overrides any older pending one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q     <= 1'b0;
            pend_cnt_q <= '0;
            pend_max_q <= 1'b0;
            pend_min_q <= 1'b0;
        end else if (time_i && state_q != IDLE) begin
            pend_q     <= 1'b1;
            pend_cnt_q <= cnt_i;
            pend_max_q <= max_i;
            pend_min_q <= min_i;
        end else if (commit) begin
            pend_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_max_q     <= 1'b0;
            sh_min_q     <= 1'b0;
            disp_units_q <= '0;
            disp_tens_q  <= '0;
            disp_max_q   <= 1'b0;
            disp_min_q   <= 1'b0;
        end else begin
            if (sh_load) begin
                sh_max_q <= ld_max;
                sh_min_q <= ld_min;
            end
            if (commit) begin
                disp_units_q <= units;
                disp_tens_q  <= tens;
                disp_max_q   <= sh_max_q;
                disp_min_q   <= sh_min_q;
            end
        end
    end

    assign flag = disp_max_q | disp_min_q;
    assign wrap = (ref_q == REFRESH_DIV - 24'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ref_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            ref_q   <= wrap ? 24'd0 : ref_q + 24'd1;
            phase_q <= phase_q ^ wrap;
        end
    end

`ifdef SEG_BLINK_EN
    logic [3:0] blink_cnt_q;
    logic       blank_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !flag) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (time_i) begin
            if (blink_cnt_q == BLINK_DIV - 4'd1) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (!phase_q) begin
            seg_d = seg_decode(disp_units_q);
            dp_d  = flag;
        end else if (disp_tens_q != 3'd0) begin
            seg_d = seg_decode({1'b0, disp_tens_q});
        end
`ifdef SEG_BLINK_EN
        if (flag && blank_q) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            seg_q <= SEG_LUT[0];
            dp_q  <= 1'b0;
            dig_q <= DIG_UNITS;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            dig_q <= phase_q ? DIG_TENS : DIG_UNITS;
        end
    end

    assign seg_o  = seg_q;
    assign dp_o   = dp_q;
    assign dig_o  = dig_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed self-checking bench for seg7_count_display (short refresh period).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg7_count_display;

    logic       clk;
    logic       rst_ni;
    logic [4:0] cnt_i;
    logic       time_i, max_i, min_i;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [1:0] dig_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    seg7_count_display #(.CNT_W(5), .REFRESH_DIV(24'd20)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .cnt_i  (cnt_i),
        .time_i (time_i),
        .max_i  (max_i),
        .min_i  (min_i),
        .seg_o  (seg_o),
        .dp_o   (dp_o),
        .dig_o  (dig_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after the tick edge k.
    task automatic tick(input logic [4:0] val, input logic mx, input logic mn);
        @(negedge clk);
        cnt_i  = val;
        max_i  = mx;
        min_i  = mn;
        time_i = 1'b1;
        @(negedge clk);
        time_i = 1'b0;
    endtask

    task automatic wait_dig(input logic [1:0] want, input string tag);
        int n = 0;
        while (dig_o !== want && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dig_o), 32'(want));
    endtask

    // Returns just after the edge on which dig_o switches to units.
    task automatic sync_units();
        wait_dig(2'b10, "sync_tens");
        wait_dig(2'b01, "sync_units");
    endtask

    initial begin
        rst_ni = 1'b0;
        cnt_i  = '0;
        time_i = 1'b0;
        max_i  = 1'b0;
        min_i  = 1'b0;

        // T1: reset state
        step(2);
        rst_ni = 1'b1;
        step(1);
        check("t1_seg",  32'(seg_o),  32'h3F);
        check("t1_dig",  32'(dig_o),  32'h1);
        check("t1_dp",   32'(dp_o),   32'h0);
        check("t1_busy", 32'(busy_o), 32'h0);

        // T2: 27, busy window and both digits
        sync_units();
        tick(5'd27, 1'b0, 1'b0);
        check("t2_busy_k", 32'(busy_o), 32'h1);
        step(5);
        check("t2_busy_k5", 32'(busy_o), 32'h1);
        step(1);
        check("t2_busy_k6", 32'(busy_o), 32'h0);
        step(2);
        check("t2_units_seg", 32'(seg_o), 32'h07);
        check("t2_units_dig", 32'(dig_o), 32'h1);
        check("t2_units_dp",  32'(dp_o),  32'h0);
        wait_dig(2'b10, "t2_tens_dig");
        check("t2_tens_seg", 32'(seg_o), 32'h5B);

        // T3: 9, leading-zero blank
        sync_units();
        tick(5'd9, 1'b0, 1'b0);
        step(8);
        check("t3_units_seg", 32'(seg_o), 32'h6F);
        wait_dig(2'b10, "t3_tens_dig");
        check("t3_tens_seg", 32'(seg_o), 32'h00);
        check("t3_tens_dp",  32'(dp_o),  32'h0);

        // T4: tick while busy goes to pending and restarts after commit
        sync_units();
        @(negedge clk);
        cnt_i  = 5'd3;
        time_i = 1'b1;
        @(negedge clk);
        time_i = 1'b0;
        @(negedge clk);
        cnt_i  = 5'd14;
        time_i = 1'b1;
        @(negedge clk);
        time_i = 1'b0;
        step(4);
        check("t4_busy_k6", 32'(busy_o), 32'h1);
        step(2);
        check("t4_first_seg", 32'(seg_o), 32'h4F);
        step(3);
        check("t4_busy_k11", 32'(busy_o), 32'h1);
        step(1);
        check("t4_busy_k12", 32'(busy_o), 32'h0);
        step(2);
        check("t4_units_seg", 32'(seg_o), 32'h66);
        check("t4_units_dig", 32'(dig_o), 32'h1);
        wait_dig(2'b10, "t4_tens_dig");
        check("t4_tens_seg", 32'(seg_o), 32'h06);

        // T7: 10, units zero not blanked
        sync_units();
        tick(5'd10, 1'b0, 1'b0);
        step(8);
        check("t7_units_seg", 32'(seg_o), 32'h3F);
        wait_dig(2'b10, "t7_tens_dig");
        check("t7_tens_seg", 32'(seg_o), 32'h06);

        // T5: 31 at max, decimal point in units phase only
        sync_units();
        tick(5'd31, 1'b1, 1'b0);
        step(8);
        check("t5_units_seg", 32'(seg_o), 32'h06);
        check("t5_units_dp",  32'(dp_o),  32'h1);
        wait_dig(2'b10, "t5_tens_dig");
        check("t5_tens_seg", 32'(seg_o), 32'h4F);
        check("t5_tens_dp",  32'(dp_o),  32'h0);

`ifdef SEG_BLINK_EN
        for (int i = 0; i < 5; i++) begin
            tick(5'd31, 1'b1, 1'b0);
            step(6);
        end
        check("t5_blink_seg", 32'(seg_o), 32'h00);
        check("t5_blink_dp",  32'(dp_o),  32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(5'd31, 1'b1, 1'b0);
            step(6);
        end
        wait_dig(2'b01, "t5_show_dig");
        check("t5_show_seg", 32'(seg_o), 32'h06);
`endif

        // T6: reset during a conversion of 20
        sync_units();
        tick(5'd20, 1'b0, 1'b0);
        max_i  = 1'b0;
        step(2);
        rst_ni = 1'b0;
        step(1);
        check("t6_rst_busy", 32'(busy_o), 32'h0);
        check("t6_rst_seg",  32'(seg_o),  32'h3F);
        check("t6_rst_dp",   32'(dp_o),   32'h0);
        rst_ni = 1'b1;
        step(10);
        check("t6_after_busy", 32'(busy_o), 32'h0);
        check("t6_after_seg",  32'(seg_o),  32'h3F);
        check("t6_after_dig",  32'(dig_o),  32'h1);
        wait_dig(2'b10, "t6_tens_dig");
        check("t6_tens_seg", 32'(seg_o), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
